// File: rtl/slavefifo2b_pkg.sv
// slavefifo2b_pkg
//
// Shared constants for the on-chip slave-FIFO responder.
//   ADDR_WR_THREAD / ADDR_RD_THREAD : FIFO address values that select the
//                                     producer (write) and consumer (read) threads
//   READ_LAT                        : edges from an accepted read strobe to the
//                                     word appearing on data_out
//   FLAG_ASSERTED / FLAG_DEASSERTED : electrical level of the FIFO flags
//   STROBE_ACTIVE                   : level of the active-low bus strobes
package slavefifo2b_pkg;

    localparam logic [1:0] ADDR_WR_THREAD  = 2'b00;
    localparam logic [1:0] ADDR_RD_THREAD  = 2'b11;
    localparam int         READ_LAT        = 2;
    localparam logic       FLAG_ASSERTED   = 1'b1;
    localparam logic       FLAG_DEASSERTED = 1'b0;
    localparam logic       STROBE_ACTIVE   = 1'b0;

    // True when an active-low strobe is being driven.
    function automatic logic strobe_on(input logic strobe_n);
        return strobe_n == STROBE_ACTIVE;
    endfunction

    // Maps a condition onto the flag pin level.
    function automatic logic flag_level(input logic cond);
        return cond ? FLAG_ASSERTED : FLAG_DEASSERTED;
    endfunction

endpackage

// File: rtl/slavefifo2b_sdp_ram.sv
// slavefifo2b_sdp_ram
//
// Simple dual-port buffer RAM: one synchronous write port, one registered
// read port. No reset on the storage or the read register; the responder
// tracks which words are valid.
//   usb_clk  : clock
//   wr_en    : write strobe for wr_addr/wr_data
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : load rd_data from rd_addr on this edge
//   rd_addr  : read address
//   rd_data  : registered read data
module slavefifo2b_sdp_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             usb_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge usb_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/slavefifo2b_responder.sv
// slavefifo2b_responder
//
// Controller-side model of the 32-bit slave-FIFO interface. Words written by
// the master on the write thread are buffered and returned in order on the
// read thread, with the four FIFO flags driven from the buffer occupancy.
//   usb_clk, reset_          : clock, asynchronous active-low reset
//   slcs_, slwr_, slrd_,
//   sloe_, pktend_           : active-low bus strobes from the master
//   address                  : thread select (write 2'b00, read 2'b11)
//   data_in                  : write data, sampled with slwr_
//   data_out, data_oe        : read data and bus drive enable
//   flaga / flagb            : not full / free space above watermark
//   flagc / flagd            : not empty / occupancy above watermark
//   occupancy                : words currently buffered
//   pkt_cnt, zlp_cnt         : committed packets / zero-length packets
//   overflow, underflow      : sticky error indications
module slavefifo2b_responder
    import slavefifo2b_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WMARK = 4
) (
    input  logic                     usb_clk,
    input  logic                     reset_,
    input  logic                     slcs_,
    input  logic                     slwr_,
    input  logic                     slrd_,
    input  logic                     sloe_,
    input  logic                     pktend_,
    input  logic [1:0]               address,
    input  logic [31:0]              data_in,
    output logic [31:0]              data_out,
    output logic                     data_oe,
    output logic                     flaga,
    output logic                     flagb,
    output logic                     flagc,
    output logic                     flagd,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              pkt_cnt,
    output logic [15:0]              zlp_cnt,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);
    localparam logic [OW-1:0] WMARK_W = OW'(WMARK);

    logic          wr_sel;
    logic          wr_req;
    logic          pkt_req;
    logic          rd_req;
    logic          is_full;
    logic          is_empty;
    logic          push;
    logic          pop;
    logic [OW-1:0] occ_next;

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_addr_q;
    logic [READ_LAT-1:0] rd_vld;
    logic [31:0]         ram_rd_data;

    // Decode the bus strobes. A write and a read can never be accepted on
    // the same edge because they require different thread addresses.
    always_comb begin
        wr_sel   = strobe_on(slcs_) && (address == ADDR_WR_THREAD);
        wr_req   = wr_sel && strobe_on(slwr_);
        pkt_req  = wr_sel && strobe_on(pktend_);
        rd_req   = strobe_on(slcs_) && strobe_on(slrd_) && (address == ADDR_RD_THREAD);
        is_full  = (occupancy == DEPTH_W);
        is_empty = (occupancy == '0);
        push     = wr_req && !is_full;
        pop      = rd_req && !is_empty;
        occ_next = occupancy;
        if (push) begin
            occ_next = occupancy + OW'(1);
        end else if (pop) begin
            occ_next = occupancy - OW'(1);
        end
    end

    assign data_oe = strobe_on(slcs_) && strobe_on(sloe_) && (address == ADDR_RD_THREAD);

    slavefifo2b_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .AW    (AW)
    ) u_ram (
        .usb_clk (usb_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_vld[0]),
        .rd_addr (rd_addr_q),
        .rd_data (ram_rd_data)
    );

    // Pointers and occupancy move on the accepting edge. The popped address
    // is held one edge so the RAM read happens on the following edge.
    always_ff @(posedge usb_clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_addr_q <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                rd_addr_q <= rd_ptr;
            end
        end
    end

    // Read pipeline: stage 0 marks the RAM read edge, the last stage marks
    // the output-register load. Reset clears in-flight words so nothing
    // from before reset reaches data_out.
    always_ff @(posedge usb_clk or negedge reset_) begin
        if (!reset_) begin
            rd_vld   <= '0;
            data_out <= '0;
        end else begin
            rd_vld <= {rd_vld[READ_LAT-2:0], pop};
            if (rd_vld[READ_LAT-1]) begin
                data_out <= ram_rd_data;
            end
        end
    end

    // Flags are registered from the occupancy register, so they trail the
    // accepting edge by one cycle; the master is expected to tolerate this.
    always_ff @(posedge usb_clk or negedge reset_) begin
        if (!reset_) begin
            flaga <= FLAG_ASSERTED;
            flagb <= FLAG_ASSERTED;
            flagc <= FLAG_DEASSERTED;
            flagd <= FLAG_DEASSERTED;
        end else begin
            flaga <= flag_level(occupancy != DEPTH_W);
            flagb <= flag_level((DEPTH_W - occupancy) > WMARK_W);
            flagc <= flag_level(occupancy != '0);
            flagd <= flag_level(occupancy > WMARK_W);
        end
    end

    // Packet counters and sticky error bits. A PKTEND commits a packet even
    // when its accompanying write was dropped on a full buffer.
    always_ff @(posedge usb_clk or negedge reset_) begin
        if (!reset_) begin
            pkt_cnt   <= '0;
            zlp_cnt   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (pkt_req) begin
                pkt_cnt <= pkt_cnt + 16'd1;
                if (!strobe_on(slwr_)) begin
                    zlp_cnt <= zlp_cnt + 16'd1;
                end
            end
            if (wr_req && is_full) begin
                overflow <= 1'b1;
            end
            if (rd_req && is_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slavefifo2b_responder.sv
// tb_slavefifo2b_responder
//
// Directed bench for slavefifo2b_responder. A queue-based model of the
// buffer tracks expected outputs and is compared against the DUT on every
// falling clock edge; the directed sequence also checks hand-computed values.
module tb_slavefifo2b_responder;

    localparam int DEPTH = 512;
    localparam int WMARK = 4;

    logic        usb_clk = 1'b0;
    logic        reset_  = 1'b1;
    logic        slcs_   = 1'b1;
    logic        slwr_   = 1'b1;
    logic        slrd_   = 1'b1;
    logic        sloe_   = 1'b1;
    logic        pktend_ = 1'b1;
    logic [1:0]  address = 2'b00;
    logic [31:0] data_in = '0;

    logic [31:0] data_out;
    logic        data_oe;
    logic        flaga, flagb, flagc, flagd;
    logic [9:0]  occupancy;
    logic [15:0] pkt_cnt, zlp_cnt;
    logic        overflow, underflow;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 usb_clk = ~usb_clk;

    slavefifo2b_responder #(
        .DEPTH (DEPTH),
        .WMARK (WMARK)
    ) dut (
        .usb_clk   (usb_clk),
        .reset_    (reset_),
        .slcs_     (slcs_),
        .slwr_     (slwr_),
        .slrd_     (slrd_),
        .sloe_     (sloe_),
        .pktend_   (pktend_),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .flaga     (flaga),
        .flagb     (flagb),
        .flagc     (flagc),
        .flagd     (flagd),
        .occupancy (occupancy),
        .pkt_cnt   (pkt_cnt),
        .zlp_cnt   (zlp_cnt),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Reference model: a queue of stored words, a list of words due on
    // data_out at a given cycle, and flags derived from the previous size.
    logic [31:0] mq [$];
    int unsigned due [$];
    logic [31:0] dword [$];
    int unsigned cyc      = 0;
    int          occ_prev = 0;
    logic [31:0] m_dout   = '0;
    logic        m_fa = 1'b1, m_fb = 1'b1, m_fc = 1'b0, m_fd = 1'b0;
    logic [15:0] m_pkt = '0, m_zlp = '0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;

    always @(posedge usb_clk or negedge reset_) begin
        if (!reset_) begin
            mq.delete();
            due.delete();
            dword.delete();
            cyc    = 0;
            m_dout = '0;
            m_fa   = 1'b1;
            m_fb   = 1'b1;
            m_fc   = 1'b0;
            m_fd   = 1'b0;
            m_pkt  = '0;
            m_zlp  = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (due.size() > 0 && due[0] == cyc) begin
                void'(due.pop_front());
                m_dout = dword.pop_front();
            end
            occ_prev = mq.size();
            m_fa = (occ_prev != DEPTH);
            m_fb = ((DEPTH - occ_prev) > WMARK);
            m_fc = (occ_prev != 0);
            m_fd = (occ_prev > WMARK);
            if (!slcs_ && address == 2'b00) begin
                if (!slwr_) begin
                    if (mq.size() < DEPTH) mq.push_back(data_in);
                    else m_ovf = 1'b1;
                end
                if (!pktend_) begin
                    m_pkt = m_pkt + 16'd1;
                    if (slwr_) m_zlp = m_zlp + 16'd1;
                end
            end
            if (!slcs_ && !slrd_ && address == 2'b11) begin
                if (mq.size() > 0) begin
                    due.push_back(cyc + 2);
                    dword.push_back(mq.pop_front());
                end else begin
                    m_unf = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic cs_n, input logic wr_n, input logic rd_n,
                                 input logic oe_n, input logic pe_n,
                                 input logic [1:0] a, input logic [31:0] d);
        slcs_   = cs_n;
        slwr_   = wr_n;
        slrd_   = rd_n;
        sloe_   = oe_n;
        pktend_ = pe_n;
        address = a;
        data_in = d;
        @(posedge usb_clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0);
    endtask

    // Model comparison on every falling edge while the bench is active.
    always @(negedge usb_clk) begin
        if (cmp_en) begin
            checkOutput("m_data_out",  data_out, m_dout);
            checkOutput("m_data_oe",   32'(data_oe), 32'(!slcs_ && !sloe_ && address == 2'b11));
            checkOutput("m_flaga",     32'(flaga), 32'(m_fa));
            checkOutput("m_flagb",     32'(flagb), 32'(m_fb));
            checkOutput("m_flagc",     32'(flagc), 32'(m_fc));
            checkOutput("m_flagd",     32'(flagd), 32'(m_fd));
            checkOutput("m_occupancy", 32'(occupancy), 32'(mq.size()));
            checkOutput("m_pkt_cnt",   32'(pkt_cnt), 32'(m_pkt));
            checkOutput("m_zlp_cnt",   32'(zlp_cnt), 32'(m_zlp));
            checkOutput("m_overflow",  32'(overflow), 32'(m_ovf));
            checkOutput("m_underflow", 32'(underflow), 32'(m_unf));
        end
    end

    initial begin
        #2 reset_ = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge usb_clk);
        @(negedge usb_clk);
        #1 reset_ = 1'b1;
        idleCycle();

        // Reset values
        checkOutput("rst_data_oe",   32'(data_oe), 32'h0);
        checkOutput("rst_flaga",     32'(flaga), 32'h1);
        checkOutput("rst_flagb",     32'(flagb), 32'h1);
        checkOutput("rst_flagc",     32'(flagc), 32'h0);
        checkOutput("rst_flagd",     32'(flagd), 32'h0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
        checkOutput("rst_pkt_cnt",   32'(pkt_cnt), 32'h0);
        checkOutput("rst_zlp_cnt",   32'(zlp_cnt), 32'h0);
        checkOutput("rst_data_out",  data_out, 32'h0);

        // Eight-word packet, PKTEND with the last word
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, (i == 7) ? 1'b0 : 1'b1, 2'b00,
                          32'h1000_0000 + 32'(i));
            if (i == 0) checkOutput("flagc_lag", 32'(flagc), 32'h0);
            if (i == 1) checkOutput("flagc_up",  32'(flagc), 32'h1);
            if (i == 4) checkOutput("flagd_lag", 32'(flagd), 32'h0);
            if (i == 5) checkOutput("flagd_up",  32'(flagd), 32'h1);
        end
        checkOutput("wr8_occupancy", 32'(occupancy), 32'd8);
        checkOutput("wr8_pkt_cnt",   32'(pkt_cnt), 32'd1);

        // Eight back-to-back reads, data two edges after each pop
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
            checkOutput("rd_data_oe", 32'(data_oe), 32'h1);
            if (k >= 2) checkOutput("rd_data", data_out, 32'h1000_0000 + 32'(k - 2));
        end
        checkOutput("rd_occupancy", 32'(occupancy), 32'h0);
        checkOutput("rd_flagc_lag", 32'(flagc), 32'h1);
        for (int k = 0; k < 2; k++) begin
            idleCycle();
            checkOutput("rd_tail", data_out, 32'h1000_0006 + 32'(k));
            if (k == 0) checkOutput("rd_flagc_down", 32'(flagc), 32'h0);
        end

        // Zero-length packet
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        checkOutput("zlp_zlp_cnt",   32'(zlp_cnt), 32'd1);
        checkOutput("zlp_pkt_cnt",   32'(pkt_cnt), 32'd2);
        checkOutput("zlp_occupancy", 32'(occupancy), 32'd0);

        // Fill to DEPTH, then one write that must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h2000_0000 + 32'(i));
        end
        checkOutput("full_occupancy", 32'(occupancy), 32'd512);
        checkOutput("full_flaga_lag", 32'(flaga), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF);
        checkOutput("ovf_flaga",     32'(flaga), 32'h0);
        checkOutput("ovf_flagb",     32'(flagb), 32'h0);
        checkOutput("ovf_overflow",  32'(overflow), 32'h1);
        checkOutput("ovf_occupancy", 32'(occupancy), 32'd512);

        // Drain everything; the dropped word must never appear
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k < DEPTH) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
            else idleCycle();
            if (k >= 2) checkOutput("drain_data", data_out, 32'h2000_0000 + 32'(k - 2));
        end
        checkOutput("drain_occupancy", 32'(occupancy), 32'd0);

        // Read from empty
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
        checkOutput("unf_underflow", 32'(underflow), 32'h1);
        checkOutput("unf_data_out",  data_out, 32'h2000_01FF);
        idleCycle();
        idleCycle();
        checkOutput("unf_data_hold", data_out, 32'h2000_01FF);

        // Reset in the middle of a four-read burst
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h3000_0000 + 32'(i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
        checkOutput("burst_occupancy", 32'(occupancy), 32'd2);
        reset_ = 1'b0;
        #1;
        checkOutput("mrst_data_out",  data_out, 32'h0);
        checkOutput("mrst_occupancy", 32'(occupancy), 32'h0);
        checkOutput("mrst_flaga",     32'(flaga), 32'h1);
        checkOutput("mrst_flagc",     32'(flagc), 32'h0);
        checkOutput("mrst_overflow",  32'(overflow), 32'h0);
        checkOutput("mrst_underflow", 32'(underflow), 32'h0);
        checkOutput("mrst_pkt_cnt",   32'(pkt_cnt), 32'h0);
        slcs_ = 1'b1;
        slrd_ = 1'b1;
        sloe_ = 1'b1;
        #1;
        checkOutput("mrst_data_oe", 32'(data_oe), 32'h0);
        @(negedge usb_clk);
        #1 reset_ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idleCycle();
            checkOutput("post_rst_data_out", data_out, 32'h0);
        end
        checkOutput("post_rst_occupancy", 32'(occupancy), 32'h0);

        cmp_en = 1'b0;
        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slavefifo2b_responder.md
# slavefifo2b_responder

Synthesizable model of the USB-controller end of the 32-bit slave-FIFO interface: it answers SLCS/SLWR/SLRD/SLOE/PKTEND/address strobes from an FPGA-side master, buffers written words, returns them on reads, and drives the four FIFO flags. It sits on-chip in place of the external controller for self-test and board bring-up, looping producer-thread writes back to the consumer thread. The tri-state data bus is split into in/out/oe for internal use.

## Interface
- DEPTH, 512: buffer depth in 32-bit words; power of two, ≥ 8.
- WMARK, 4: partial-flag watermark in words.
- usb_clk  input  1  single clock; all logic on rising edge.
- reset_  input  1  asynchronous, active-low reset.
- slcs_  input  1  chip select, active low.
- slwr_  input  1  write strobe, active low.
- slrd_  input  1  read strobe, active low.
- sloe_  input  1  output enable, active low.
- pktend_  input  1  packet end, active low.
- address  input  2  thread select: 2'b00 write thread, 2'b11 read thread.
- data_in  input  32  bus data from master.
- data_out  output  32  bus data to master.
- data_oe  output  1  bus drive enable.
- flaga  output  1  high = write thread not full.
- flagb  output  1  high = free space > WMARK.
- flagc  output  1  high = read thread not empty.
- flagd  output  1  high = occupancy > WMARK.
- occupancy  output  log2(DEPTH)+1  words stored.
- pkt_cnt  output  16  committed packets (wraps).
- zlp_cnt  output  16  zero-length packets (wraps).
- overflow  output  1  sticky: write while full.
- underflow  output  1  sticky: read while empty.

## Operation
- Reset: occupancy 0, pointers 0, data_out 0, data_oe 0, flaga 1, flagb 1, flagc 0, flagd 0, counters 0, overflow 0, underflow 0. Reset mid-transfer discards buffer and in-flight read words.
- Write accept: slcs_=0, slwr_=0, address=2'b00 at edge → data_in pushed. slwr_ with other address ignored.
- Full write: word dropped, overflow set, occupancy unchanged.
- Read accept: slcs_=0, slrd_=0, address=2'b11, not empty → pop. Empty read: no pop, underflow set, data_out holds.
- PKTEND: slcs_=0, pktend_=0, address=2'b00. With accepted write same edge → word pushed, pkt_cnt+1. With slwr_=1 → zlp_cnt+1, pkt_cnt+1, nothing pushed. With dropped write (full) → pkt_cnt still +1.
- Same-edge accepted write and read impossible (one address); pops whose data is in flight proceed while writes resume.
- data_oe = ~slcs_ & ~sloe_ & (address==2'b11), combinational.
- Occupancy: +1 per push, −1 per pop, saturates at DEPTH; pointers wrap modulo DEPTH.
- Counters wrap 16'hFFFF → 0. overflow/underflow clear only on reset.

## Timing
- Write: data_in sampled on the same edge as slwr_ low; zero latency.
- Read latency 2: pop at edge N → word on data_out after edge N+2 (edge N+1 registered RAM read, N+2 output register). Back-to-back slrd_ gives one word per cycle.
- occupancy updates at accept edge; flags registered from it, valid one cycle later. Master must allow one-cycle flag lag; flaga deasserts one cycle after the DEPTH-th write, flagc one cycle after first write.
- flagb/flagd compare post-update occupancy against WMARK; strict greater-than.

## Structure
- Package slavefifo2b_pkg: ADDR_WR_THREAD=2'b00, ADDR_RD_THREAD=2'b11, READ_LAT=2, flag polarity constants.
- Sub-module slavefifo2b_sdp_ram: simple dual-port RAM, one write port, registered read port, DEPTH×32; responder holds pointers, occupancy, flags, counters, output register.

## Test plan
- Reset release → data_oe=0, flaga=1, flagb=1, flagc=0, flagd=0, occupancy=0, all counters 0.
- Write 8 words 32'h1000_0000..32'h1000_0007 to 2'b00, pktend_ with last → occupancy 8, pkt_cnt 1, flagc=1 one cycle after first write, flagd=1 one cycle after fifth write.
- Assert sloe_ and slrd_ at 2'b11 for 8 cycles → data_out 32'h1000_0000..0007 consecutively starting 2 cycles after first slrd_, occupancy 0, flagc=0 one cycle after last pop.
- pktend_ low, slwr_ high, address 2'b00 → zlp_cnt 1, pkt_cnt +1, occupancy unchanged.
- Fill DEPTH=512 words then one extra write 32'hDEAD_BEEF → flaga=0, overflow=1, occupancy 512; drain shows no 32'hDEAD_BEEF.
- Read from empty → underflow=1, data_out unchanged; assert reset_ mid-burst of 4 reads → all outputs at reset values next cycle.
